// File: rtl/uart_rx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_pkg
//   Shared UART definitions: receiver FSM state encoding, data width and a
//   helper that zero-extends a received byte onto the 32-bit read bus.
// ---------------------------------------------------------------------------
package uart_rx_fifo_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    function automatic logic [31:0] zext_byte(input logic [UART_DATA_BITS-1:0] b);
        return {{(32-UART_DATA_BITS){1'b0}}, b};
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
//   Register-side interface of the UART receive path.
//   master : bus/address-decode side (drives rd_en, clr_err)
//   slave  : receiver side (drives head data, FIFO status, sticky flags)
//   Signals:
//     rd_en        pop head byte this cycle
//     clr_err      clear sticky error flags
//     o_data       head byte zero-extended, 0 when empty
//     o_empty      FIFO empty
//     o_full       FIFO full (Rfull)
//     o_count      bytes held
//     o_overrun    sticky: byte dropped on full FIFO
//     o_frame_err  sticky: stop bit sampled low
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int CNT_W = 4
) ();
    logic             rd_en;
    logic             clr_err;
    logic [31:0]      o_data;
    logic             o_empty;
    logic             o_full;
    logic [CNT_W-1:0] o_count;
    logic             o_overrun;
    logic             o_frame_err;

    modport master (
        output rd_en, clr_err,
        input  o_data, o_empty, o_full, o_count, o_overrun, o_frame_err
    );

    modport slave (
        input  rd_en, clr_err,
        output o_data, o_empty, o_full, o_count, o_overrun, o_frame_err
    );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_sync_fifo
//   First-word fall-through synchronous FIFO, reusable by RX and TX paths.
//   Ports:
//     clk, rst_n   clock, async active-low reset
//     push_i       write data_i this cycle
//     data_i       write data
//     pop_i        advance head this cycle (ignored when empty)
//     data_o       head entry, 0 when empty
//     empty_o      no entries held
//     full_o       DEPTH entries held
//     count_o      entries held, 0..DEPTH
//     drop_o       push rejected because full with no pop this cycle
// ---------------------------------------------------------------------------
module uart_rx_fifo_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o,
    output logic             drop_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push on a full FIFO is
    // still accepted then; when full, wr_ptr equals rd_ptr and the head
    // being overwritten is the one leaving.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && !do_push;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   UART serial receive front end: synchronises i_Rx, decodes 8N1 frames
//   LSB first, and buffers received bytes in a FIFO read by the CPU bus.
//   Ports:
//     clk    system clock
//     rst_n  async active-low reset
//     i_Rx   serial line, idle high, asynchronous to clk
//     bus    uart_rx_fifo_if.slave: rd_en, clr_err in; o_data, o_empty,
//            o_full, o_count, o_overrun, o_frame_err out
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | line idle, waiting for a low sample
//   ST_START | half-bit wait, confirm start bit still low
//   ST_DATA  | sample one data bit per bit period, 8 bits LSB first
//   ST_STOP  | sample stop bit; high pushes byte, low flags frame error
//   ST_BREAK | stop bit was low, wait for line to return high
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_Rx,
    uart_rx_fifo_if.slave bus
);

    localparam int TICK_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(UART_DATA_BITS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

    logic                      sync1_q;
    logic                      sync2_q;
    logic                      rx_s;
    rx_state_e                 state_q;
    logic [TICK_W-1:0]         tick_q;
    logic [BIT_W-1:0]          bit_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      push_q;
    logic                      frame_err_q;
    logic                      overrun_q;

    logic [UART_DATA_BITS-1:0] fifo_data;
    logic                      fifo_drop;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic [CNT_W-1:0]          fifo_count;

    // Flops reset to idle-high so a reset never fakes a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_Rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            // Clear first so a frame error detected this cycle wins.
            if (bus.clr_err) begin
                frame_err_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        tick_q  <= '0;
                        bit_q   <= '0;
                    end
                end
                ST_START: begin
                    if (tick_q == TICK_HALF) begin
                        tick_q  <= '0;
                        state_q <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q  <= '0;
                        shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        if (rx_s) begin
                            push_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        tick_q  <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    tick_q  <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (fifo_drop) begin
            overrun_q <= 1'b1;
        end else if (bus.clr_err) begin
            overrun_q <= 1'b0;
        end
    end

    uart_rx_fifo_sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_q),
        .data_i  (shift_q),
        .pop_i   (bus.rd_en),
        .data_o  (fifo_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count),
        .drop_o  (fifo_drop)
    );

    assign bus.o_data      = zext_byte(fifo_data);
    assign bus.o_empty     = fifo_empty;
    assign bus.o_full      = fifo_full;
    assign bus.o_count     = fifo_count;
    assign bus.o_overrun   = overrun_q;
    assign bus.o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.CNT_W(CW)) bus ();

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .CNT_W        (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_Rx  (rx),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One 8N1 frame: start, 8 data bits LSB first, stop (value given).
    // Returns on the falling edge right after the stop bit period.
    task automatic send(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, bus.o_data, {24'h0, exp});
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_empty", bus.o_empty, 1);
        chk("rst_full", bus.o_full, 0);
        chk("rst_count", bus.o_count, 0);
        chk("rst_data", bus.o_data, 32'h0);
        chk("rst_ovr", bus.o_overrun, 0);
        chk("rst_ferr", bus.o_frame_err, 0);

        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        @(negedge clk);
        chk("underflow_empty", bus.o_empty, 1);
        chk("underflow_count", bus.o_count, 0);
        chk("underflow_data", bus.o_data, 32'h0);

        // Single byte 0xA5
        send(8'hA5, 1'b1);
        idle(4);
        chk("a5_count", bus.o_count, 1);
        chk("a5_empty", bus.o_empty, 0);
        pop_chk("a5_data", 8'hA5);
        chk("a5_popped_empty", bus.o_empty, 1);

        // Fill and overrun
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), 1'b1);
            idle(4);
        end
        chk("fill_full", bus.o_full, 1);
        chk("fill_count", bus.o_count, 4);
        chk("fill_ovr", bus.o_overrun, 0);
        send(8'h05, 1'b1);
        idle(4);
        chk("ovr_flag", bus.o_overrun, 1);
        chk("ovr_count", bus.o_count, 4);
        pop_chk("ovr_pop1", 8'h01);
        pop_chk("ovr_pop2", 8'h02);
        pop_chk("ovr_pop3", 8'h03);
        pop_chk("ovr_pop4", 8'h04);
        chk("ovr_drained", bus.o_empty, 1);
        chk("ovr_still_set", bus.o_overrun, 1);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        chk("ovr_cleared", bus.o_overrun, 0);

        // Full FIFO, pop lands on the push cycle of byte 0x06
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), 1'b1);
            idle(4);
        end
        chk("pp_full", bus.o_count, 4);
        send(8'h06, 1'b1);
        @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        idle(3);
        chk("pp_count", bus.o_count, 4);
        chk("pp_ovr", bus.o_overrun, 0);
        pop_chk("pp_pop1", 8'h02);
        pop_chk("pp_pop2", 8'h03);
        pop_chk("pp_pop3", 8'h04);
        pop_chk("pp_pop4", 8'h06);
        chk("pp_drained", bus.o_empty, 1);

        // Bad stop bit with clr_err held across the stop sample, then line held low
        bus.clr_err = 1'b1;
        send(8'h3C, 1'b0);
        @(negedge clk);
        bus.clr_err = 1'b0;
        @(negedge clk);
        chk("ferr_set_beats_clr", bus.o_frame_err, 1);
        repeat (14) @(negedge clk);
        chk("ferr_held", bus.o_frame_err, 1);
        chk("ferr_count", bus.o_count, 0);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        repeat (60) @(negedge clk);
        chk("break_no_retrigger", bus.o_frame_err, 0);
        chk("break_count", bus.o_count, 0);
        idle(60);
        chk("break_release_count", bus.o_count, 0);
        chk("break_release_ferr", bus.o_frame_err, 0);

        // One-cycle glitch on an idle line
        rx = 1'b0;
        @(negedge clk);
        idle(30);
        chk("glitch_empty", bus.o_empty, 1);
        chk("glitch_ferr", bus.o_frame_err, 0);

        // Reset in the middle of a frame
        send(8'h77, 1'b1);
        idle(4);
        chk("mid_pre_count", bus.o_count, 1);
        rx = 1'b0;
        repeat (CPB * 2) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_count", bus.o_count, 0);
        chk("mid_rst_empty", bus.o_empty, 1);
        chk("mid_rst_data", bus.o_data, 32'h0);
        rst_n = 1'b1;
        idle(8);
        send(8'h5A, 1'b1);
        idle(4);
        chk("post_rst_count", bus.o_count, 1);
        chk("post_rst_ferr", bus.o_frame_err, 0);
        pop_chk("post_rst_data", 8'h5A);
        chk("post_rst_empty", bus.o_empty, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
